// File: rtl/axi_lite_write_slave_pkg.sv
// Shared definitions for the AXI4-Lite write slave.
//   RESP_OKAY / RESP_SLVERR : BRESP encodings
//   state_e                 : write-path FSM states
//   clog2()                 : index width for the register decode
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Ceiling log2; a value of 1 yields 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_write_slave_if.sv
// AXI4-Lite write channels (AW, W, B) bundled for the write slave.
//   master modport : drives VALIDs, payloads and BREADY
//   slave  modport : drives AWREADY, WREADY, BVALID and BRESP
interface axi_lite_write_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    AWVALID;
  logic                    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    WVALID;
  logic                    WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    BVALID;
  logic                    BREADY;
  logic [1:0]              BRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );

endinterface

// File: rtl/axi_lite_write_slave_hold_reg.sv
// Single-entry channel hold register with its own registered READY.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   valid_i       : channel VALID
//   ready_o       : channel READY (registered)
//   allow_i       : the FSM will be idle next cycle, so READY may rise
//   clear_i       : drop the held entry (write completed)
//   payload_i/o   : captured channel payload
//   full_o        : an entry is held
module axi_lite_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             allow_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] payload_i,
  output logic             full_o,
  output logic [WIDTH-1:0] payload_o
);

  logic             ready_q;
  logic             full_q;
  logic             full_d;
  logic [WIDTH-1:0] payload_q;
  logic             accept;

  assign accept = valid_i & ready_q;

  // READY is never high while clear is asserted, so clear cannot collide
  // with a new handshake.
  always_comb begin
    full_d = full_q | accept;
    if (clear_i) begin
      full_d = 1'b0;
    end
  end

  // READY is computed from the next full state so it drops on the same
  // edge that captures the payload.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ready_q   <= 1'b0;
      full_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      ready_q <= allow_i & ~full_d;
      full_q  <= full_d;
      if (accept) begin
        payload_q <= payload_i;
      end
    end
  end

  assign ready_o   = ready_q;
  assign full_o    = full_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write-path slave: joins independent AW and W transfers into one
// register-file write strobe and returns a B response. One write in flight.
//   ACLK, ARESETn : clock, synchronous active-low reset
//   bus           : AW/W/B channels (slave side)
//   reg_wr_en     : one-cycle write strobe to the register file
//   reg_wr_idx    : word register index
//   reg_wr_data   : write data
//   reg_wr_strb   : byte enables
module axi_lite_write_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  axi_lite_write_slave_if.slave       bus,
  output logic                        reg_wr_en,
  output logic [clog2(NUM_REGS)-1:0]  reg_wr_idx,
  output logic [DATA_WIDTH-1:0]       reg_wr_data,
  output logic [DATA_WIDTH/8-1:0]     reg_wr_strb
);

  localparam int          IDX_W      = clog2(NUM_REGS);
  localparam int          STRB_W     = DATA_WIDTH / 8;
  localparam logic [63:0] ADDR_LIMIT = 64'(NUM_REGS) * 64'd4;

  state_e                  state_q;
  logic                    bvalid_q;
  logic [1:0]              bresp_q;
  logic                    wr_en_q;
  logic [IDX_W-1:0]        wr_idx_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [STRB_W-1:0]       wr_strb_q;

  logic                    aw_full;
  logic                    w_full;
  logic [ADDR_WIDTH+2:0]   aw_held;
  logic [DATA_WIDTH+STRB_W-1:0] w_held;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [STRB_W-1:0]       w_strb;
  logic                    b_hs;
  logic                    allow;
  logic                    dec_err;
  logic                    unused_prot;

  assign b_hs  = (state_q == ST_RESP) & bvalid_q & bus.BREADY;
  // Idle next cycle: already idle, or the response completes this edge.
  assign allow = (state_q == ST_IDLE) | b_hs;

  axi_lite_hold_reg #(.WIDTH(ADDR_WIDTH + 3)) u_aw_hold (
    .clk_i     (ACLK),
    .rst_ni    (ARESETn),
    .valid_i   (bus.AWVALID),
    .ready_o   (bus.AWREADY),
    .allow_i   (allow),
    .clear_i   (b_hs),
    .payload_i ({bus.AWPROT, bus.AWADDR}),
    .full_o    (aw_full),
    .payload_o (aw_held)
  );

  axi_lite_hold_reg #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_hold (
    .clk_i     (ACLK),
    .rst_ni    (ARESETn),
    .valid_i   (bus.WVALID),
    .ready_o   (bus.WREADY),
    .allow_i   (allow),
    .clear_i   (b_hs),
    .payload_i ({bus.WSTRB, bus.WDATA}),
    .full_o    (w_full),
    .payload_o (w_held)
  );

  assign aw_addr = aw_held[ADDR_WIDTH-1:0];
  assign w_data  = w_held[DATA_WIDTH-1:0];
  assign w_strb  = w_held[DATA_WIDTH +: STRB_W];

  // Protection bits are held with the address but do not affect decode.
  assign unused_prot = ^aw_held[ADDR_WIDTH +: 3];

  // Range check is done on the full address so high bits cannot alias
  // into the register window.
  assign dec_err = (aw_addr[1:0] != 2'b00) || (64'(aw_addr) >= ADDR_LIMIT);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Decode is resolved on entry so the strobe is high during WRITE.
          if (aw_full && w_full) begin
            state_q <= ST_WRITE;
            bresp_q <= dec_err ? RESP_SLVERR : RESP_OKAY;
            if (!dec_err) begin
              wr_en_q   <= 1'b1;
              wr_idx_q  <= aw_addr[2 +: IDX_W];
              wr_data_q <= w_data;
              wr_strb_q <= w_strb;
            end
          end
        end
        ST_WRITE: begin
          state_q  <= ST_RESP;
          bvalid_q <= 1'b1;
        end
        ST_RESP: begin
          if (b_hs) begin
            state_q  <= ST_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_idx  = wr_idx_q;
  assign reg_wr_data = wr_data_q;
  assign reg_wr_strb = wr_strb_q;

endmodule

// File: tb/tb_axi_lite_write_slave.sv
module tb_axi_lite_write_slave;
  import axi_lite_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  exp_resp;
    logic        exp_en;
    logic [3:0]  exp_idx;
  } vec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic [3:0]  strb;
  } strobe_t;

  logic ACLK;
  logic ARESETn;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;

  int checks;
  int errors;
  strobe_t sq[$];
  vec_t vecs[10];

  axi_lite_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_write_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .bus         (bus),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_idx  (reg_wr_idx),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Record every strobe seen by the register file.
  always @(negedge ACLK) begin
    if (reg_wr_en === 1'b1) begin
      sq.push_back('{idx: reg_wr_idx, data: reg_wr_data, strb: reg_wr_strb});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, bus.AWREADY, 0);
    check({tag, "_wready"},  bus.WREADY, 0);
    check({tag, "_bvalid"},  bus.BVALID, 0);
    check({tag, "_bresp"},   bus.BRESP, 0);
    check({tag, "_wr_en"},   reg_wr_en, 0);
    check({tag, "_idx"},     reg_wr_idx, 0);
    check({tag, "_data"},    reg_wr_data, 0);
    check({tag, "_strb"},    reg_wr_strb, 0);
  endtask

  task automatic send_aw(input logic [31:0] addr, input int dly);
    bit done;
    repeat (dly) @(posedge ACLK);
    if (dly > 0) #1;
    bus.AWVALID = 1'b1;
    bus.AWADDR  = addr;
    done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge ACLK);
      if (bus.AWREADY === 1'b1) begin
        @(posedge ACLK);
        #1;
        bus.AWVALID = 1'b0;
        done = 1;
      end
    end
    if (!done) fail_timeout("aw_handshake");
    else begin
      @(negedge ACLK);
      check("awready_low_after_hs", bus.AWREADY, 0);
    end
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    bit done;
    repeat (dly) @(posedge ACLK);
    if (dly > 0) #1;
    bus.WVALID = 1'b1;
    bus.WDATA  = data;
    bus.WSTRB  = strb;
    done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge ACLK);
      if (bus.WREADY === 1'b1) begin
        @(posedge ACLK);
        #1;
        bus.WVALID = 1'b0;
        done = 1;
      end
    end
    if (!done) fail_timeout("w_handshake");
    else begin
      @(negedge ACLK);
      check("wready_low_after_hs", bus.WREADY, 0);
    end
  endtask

  // Starts just after a rising edge; returns at a falling edge.
  task automatic do_write(input int num, input vec_t v);
    int n0;
    bit got;
    logic [1:0] resp;
    n0 = sq.size();
    bus.BREADY = (v.b_dly == 0);
    fork
      send_aw(v.addr, v.aw_dly);
      send_w(v.data, v.strb, v.w_dly);
    join
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      if (bus.BVALID === 1'b1) got = 1;
      else @(negedge ACLK);
    end
    resp = bus.BRESP;
    if (!got) begin
      fail_timeout("bvalid_wait");
    end else begin
      for (int c = 0; c < v.b_dly; c++) begin
        check("bvalid_held", bus.BVALID, 1);
        check("bresp_stable", bus.BRESP, v.exp_resp);
        check("awready_during_resp", bus.AWREADY, 0);
        check("wready_during_resp", bus.WREADY, 0);
        @(negedge ACLK);
      end
      bus.BREADY = 1'b1;
      @(posedge ACLK);
      #1;
      bus.BREADY = 1'b0;
      @(negedge ACLK);
      check("bvalid_drop_after_b", bus.BVALID, 0);
    end
    check("bresp", resp, v.exp_resp);
    check("strobe_count", sq.size() - n0, v.exp_en ? 1 : 0);
    if (v.exp_en && sq.size() > n0) begin
      check("strobe_idx",  sq[n0].idx,  v.exp_idx);
      check("strobe_data", sq[n0].data, v.data);
      check("strobe_strb", sq[n0].strb, v.strb);
    end
    $display("txn %0d addr=%08h data=%08h strb=%h resp=%b strobes=%0d",
             num, v.addr, v.data, v.strb, resp, sq.size() - n0);
    @(posedge ACLK);
    #1;
  endtask

  // After release: READYs low until the first edge, then high; no activity.
  task automatic release_and_quiet(input string tag, input int nrec);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check({tag, "_awready_pre"}, bus.AWREADY, 0);
    check({tag, "_wready_pre"},  bus.WREADY, 0);
    @(negedge ACLK);
    check({tag, "_awready_post"}, bus.AWREADY, 1);
    check({tag, "_wready_post"},  bus.WREADY, 1);
    bus.BREADY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge ACLK);
      check({tag, "_no_wr_en"},  reg_wr_en, 0);
      check({tag, "_no_bvalid"}, bus.BVALID, 0);
    end
    check({tag, "_no_strobe"}, sq.size(), nrec);
    bus.BREADY = 1'b0;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int n0;
    int nrec;
    int okays;
    vec_t v;

    checks = 0;
    errors = 0;
    vecs[0] = '{32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, RESP_OKAY,   1'b1, 4'd2};
    vecs[1] = '{32'h0000_003C, 32'h1234_5678, 4'h3, 3, 0, 0, RESP_OKAY,   1'b1, 4'd15};
    vecs[2] = '{32'h0000_0040, 32'hAAAA_5555, 4'hF, 0, 0, 0, RESP_SLVERR, 1'b0, 4'd0};
    vecs[3] = '{32'h0000_0006, 32'h1111_2222, 4'hF, 0, 1, 0, RESP_SLVERR, 1'b0, 4'd0};
    vecs[4] = '{32'h0000_000C, 32'hCAFE_F00D, 4'h0, 1, 0, 0, RESP_OKAY,   1'b1, 4'd3};
    vecs[5] = '{32'h8000_0008, 32'h0BAD_F00D, 4'hF, 0, 0, 0, RESP_SLVERR, 1'b0, 4'd0};
    vecs[6] = '{32'h0000_0024, 32'h5A5A_5A5A, 4'h9, 0, 2, 5, RESP_OKAY,   1'b1, 4'd9};
    vecs[7] = '{32'h0000_003D, 32'h7777_8888, 4'hF, 2, 2, 1, RESP_SLVERR, 1'b0, 4'd0};
    vecs[8] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'h5, 0, 3, 0, RESP_OKAY,   1'b1, 4'd0};
    vecs[9] = '{32'h0000_0100, 32'h0101_0101, 4'hF, 1, 1, 2, RESP_SLVERR, 1'b0, 4'd0};

    ARESETn     = 1'b0;
    bus.AWVALID = 1'b0;
    bus.AWADDR  = '0;
    bus.AWPROT  = 3'b000;
    bus.WVALID  = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.BREADY  = 1'b0;

    // Reset state and READY rise one edge after release.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("reset");
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("awready_before_first_edge", bus.AWREADY, 0);
    @(negedge ACLK);
    check("awready_after_release", bus.AWREADY, 1);
    check("wready_after_release",  bus.WREADY, 1);
    @(posedge ACLK);
    #1;

    // Cycle-accurate same-cycle AW/W write to 0x08.
    n0 = sq.size();
    bus.AWVALID = 1'b1;
    bus.AWADDR  = 32'h0000_0008;
    bus.AWPROT  = 3'b010;
    bus.WVALID  = 1'b1;
    bus.WDATA   = 32'hDEAD_BEEF;
    bus.WSTRB   = 4'hF;
    bus.BREADY  = 1'b1;
    @(posedge ACLK);
    #1;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    @(negedge ACLK);
    check("t1_n_awready", bus.AWREADY, 0);
    check("t1_n_wready",  bus.WREADY, 0);
    check("t1_n_wr_en",   reg_wr_en, 0);
    @(negedge ACLK);
    check("t1_n1_wr_en",  reg_wr_en, 1);
    check("t1_n1_idx",    reg_wr_idx, 2);
    check("t1_n1_data",   reg_wr_data, 32'hDEAD_BEEF);
    check("t1_n1_strb",   reg_wr_strb, 4'hF);
    check("t1_n1_bvalid", bus.BVALID, 0);
    @(negedge ACLK);
    check("t1_n2_wr_en",  reg_wr_en, 0);
    check("t1_n2_bvalid", bus.BVALID, 1);
    check("t1_n2_bresp",  bus.BRESP, RESP_OKAY);
    check("t1_n2_awready", bus.AWREADY, 0);
    @(negedge ACLK);
    check("t1_n3_bvalid",  bus.BVALID, 0);
    check("t1_n3_awready", bus.AWREADY, 1);
    check("t1_n3_wready",  bus.WREADY, 1);
    check("t1_strobes",    sq.size() - n0, 1);
    $display("txn hand addr=00000008 data=deadbeef strb=f cycle-accurate");
    bus.BREADY = 1'b0;
    @(posedge ACLK);
    #1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      do_write(i, vecs[i]);
    end

    // Reset while in WRITE.
    bus.AWVALID = 1'b1;
    bus.AWADDR  = 32'h0000_0010;
    bus.WVALID  = 1'b1;
    bus.WDATA   = 32'h1357_9BDF;
    bus.WSTRB   = 4'hF;
    bus.BREADY  = 1'b1;
    @(posedge ACLK);
    #1;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("rst_write");
    nrec = sq.size();
    release_and_quiet("rst_write", nrec);

    // Reset while in RESP with BREADY low.
    bus.BREADY  = 1'b0;
    bus.AWVALID = 1'b1;
    bus.AWADDR  = 32'h0000_0014;
    bus.WVALID  = 1'b1;
    bus.WDATA   = 32'h2468_ACE0;
    bus.WSTRB   = 4'hF;
    @(posedge ACLK);
    #1;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    check("rst_resp_bvalid_before", bus.BVALID, 1);
    ARESETn = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("rst_resp");
    nrec = sq.size();
    release_and_quiet("rst_resp", nrec);

    // Back-to-back writes with random AW/W skew.
    okays = 0;
    for (int i = 0; i < 8; i++) begin
      v.exp_idx  = 4'((i * 5) % 16);
      v.addr     = {26'd0, v.exp_idx, 2'b00};
      v.data     = $urandom;
      v.strb     = 4'hF;
      v.aw_dly   = int'($urandom_range(0, 3));
      v.w_dly    = int'($urandom_range(0, 3));
      v.b_dly    = 0;
      v.exp_resp = RESP_OKAY;
      v.exp_en   = 1'b1;
      n0 = errors;
      do_write(100 + i, v);
      if (errors == n0) okays++;
    end
    check("b2b_clean_writes", okays, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
